agent_txn_gen: RTL and testbench

//  Hardware transaction agent: accepts test commands, expands them into packet transactions for the bus drivers.

---
 rtl/agent_txn_gen.sv | 139 +++++++++++++
 tb/tb_agent_txn_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/agent_txn_gen.sv
// Transaction agent: expands test commands (specific, broadcast, random burst) into driver packets.
// Optional accepted-transaction counter enabled by defining AGENT_TXN_COUNT_EN.
module agent_txn_gen #(
  parameter int          WIDTH = 40,
  parameter int          DEPTH = 8,
  parameter int          DRVRS = 4,
  parameter logic [31:0] SEED  = 32'hACE1_1234
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [$clog2(DRVRS)-1:0] cmd_src,
  input  logic [3:0]               cmd_len,
  input  logic [WIDTH-1:0]         cmd_data,
  output logic                     drv_valid,
  input  logic                     drv_ready,
  output logic [$clog2(DRVRS)-1:0] drv_src,
  output logic [WIDTH-1:0]         drv_dato,
  output logic                     busy,
  output logic                     cmd_err,
  output logic [31:0]              txn_count
);

  localparam int          SW      = $clog2(DRVRS);
  localparam logic [31:0] DEPTH_W = DEPTH;
  localparam logic [1:0]  OP_RND  = 2'd0;
  localparam logic [1:0]  OP_BC   = 2'd2;
  localparam logic [1:0]  OP_ILL  = 2'd3;

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_op;
  logic [SW-1:0]      r_src;
  logic [WIDTH-1:0]   r_data;
  logic [3:0]         r_left;
  logic [31:0]        r_lfsr;
  logic               r_err;
  logic               w_accept;
  logic               w_xfer;
  logic [3:0]         w_len;
  logic               w_fb;
  logic [7:0]         w_dest;
  logic [WIDTH-9:0]   w_pay;

  // Commands transfer on cmd_valid & cmd_ready, transactions on drv_valid & drv_ready;
  // an offered transaction holds drv_src/drv_dato stable until it transfers.
  assign w_accept = cmd_valid & cmd_ready;
  assign w_xfer   = drv_valid & drv_ready;
  assign w_fb     = r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0];
  assign w_dest   = r_lfsr[15:8] & 8'(DRVRS - 1);

  always_comb begin
    w_len = cmd_len;
    if (cmd_len == 4'd0)
      w_len = 4'd1;
    else if ({28'd0, cmd_len} > DEPTH_W)
      w_len = DEPTH_W[3:0];
  end

  // Payload is the low bits of {lfsr,lfsr}, i.e. the LFSR repeated.
  always_comb begin
    w_pay = '0;
    for (int i = 0; i < WIDTH - 8; i++)
      w_pay[i] = r_lfsr[i % 32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept && cmd_op != OP_ILL) w_next = S_EMIT;
      S_EMIT: if (w_xfer && r_left == 4'd1)     w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (r_state == S_IDLE) & ~rst;
    busy      = (r_state == S_EMIT);
    drv_valid = (r_state == S_EMIT);
    drv_src   = '0;
    drv_dato  = '0;
    if (r_state == S_EMIT) begin
      if (r_op == OP_RND) begin
        drv_src  = r_lfsr[SW-1:0];
        drv_dato = {w_dest, w_pay};
      end else begin
        drv_src  = r_src;
        drv_dato = r_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= '0;
      r_src  <= '0;
      r_data <= '0;
      r_left <= '0;
      r_lfsr <= SEED;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_accept && (cmd_op == OP_ILL);
      if (w_accept) begin
        r_op   <= cmd_op;
        r_src  <= cmd_src;
        r_data <= (cmd_op == OP_BC) ? {8'hFF, cmd_data[WIDTH-9:0]} : cmd_data;
        r_left <= (cmd_op == OP_RND) ? w_len : 4'd1;
      end
      if (w_xfer) begin
        r_left <= r_left - 4'd1;
        if (r_op == OP_RND)
          r_lfsr <= {r_lfsr[30:0], w_fb};
      end
    end
  end

  assign cmd_err = r_err;

`ifdef AGENT_TXN_COUNT_EN
  logic [31:0] r_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_count <= '0;
    else if (w_xfer) r_count <= r_count + 32'd1;
  end
  assign txn_count = r_count;
`else
  assign txn_count = 32'd0;
`endif

endmodule

// File: tb/tb_agent_txn_gen.sv
// Scoreboard bench for agent_txn_gen: directed commands push expected transactions,
// a monitor pops and compares each transferred transaction.
module tb_agent_txn_gen;

  localparam int          WIDTH = 40;
  localparam int          DEPTH = 8;
  localparam int          DRVRS = 4;
  localparam logic [31:0] SEED  = 32'hACE1_1234;
  localparam int          SW    = $clog2(DRVRS);
  localparam int          TW    = SW + WIDTH;
  // First random transaction from SEED: src=0x34&3, dest=0x12%4, payload=SEED.
  localparam logic [TW-1:0] FIRST_RND = {2'd0, 40'h02ACE11234};

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [SW-1:0]    cmd_src;
  logic [3:0]       cmd_len;
  logic [WIDTH-1:0] cmd_data;
  logic             drv_valid;
  logic             drv_ready;
  logic [SW-1:0]    drv_src;
  logic [WIDTH-1:0] drv_dato;
  logic             busy;
  logic             cmd_err;
  logic [31:0]      txn_count;

  logic [TW-1:0] exp_q[$];
  int            checks   = 0;
  int            failures = 0;
  int            n_xfer   = 0;
  logic [31:0]   m_lfsr;

  agent_txn_gen #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DRVRS(DRVRS), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .drv_valid(drv_valid), .drv_ready(drv_ready), .drv_src(drv_src),
    .drv_dato(drv_dato), .busy(busy), .cmd_err(cmd_err), .txn_count(txn_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  function automatic logic [TW-1:0] rnd_txn(input logic [31:0] l);
    logic [WIDTH-9:0] p;
    logic [7:0]       d;
    for (int i = 0; i < WIDTH - 8; i++) p[i] = l[i % 32];
    d = 8'(l[15:8] % DRVRS);
    return {l[SW-1:0], d, p};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic push_rnd(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(rnd_txn(m_lfsr));
      m_lfsr = lfsr_next(m_lfsr);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [SW-1:0] src,
                          input logic [3:0] len, input logic [WIDTH-1:0] data);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
    cmd_op = op; cmd_src = src; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); #2; n++; end
    while ((busy || exp_q.size() != 0) && n < 300);
    chk("idle_timeout", {63'd0, (busy || exp_q.size() != 0)}, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    m_lfsr = SEED;
    exp_q.delete();
    #2;
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    chk("rst_drv_valid", {63'd0, drv_valid}, 64'd0);
    chk("rst_busy",      {63'd0, busy},      64'd0);
    chk("rst_cmd_err",   {63'd0, cmd_err},   64'd0);
    chk("rst_drv_dato",  {24'd0, drv_dato},  64'd0);
    chk("rst_txn_count", {32'd0, txn_count}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // scoreboard monitor
  initial begin
    logic [TW-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && drv_valid && drv_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_txn: got %h expected none (t=%0t)", {drv_src, drv_dato}, $time);
        end else begin
          e = exp_q.pop_front();
          chk("txn", {22'd0, drv_src, drv_dato}, {22'd0, e});
        end
        n_xfer++;
      end
    end
  end

  initial begin
    int base, n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_src = '0; cmd_len = '0;
    cmd_data = '0; drv_ready = 1'b0; m_lfsr = SEED;
    do_reset();

    // 1: specific, ready high
    drv_ready = 1'b1;
    exp_q.push_back({2'd2, 40'h01DEADBEEF});
    send_cmd(2'd1, 2'd2, 4'd0, 40'h01DEADBEEF);
    @(negedge clk); #2;
    chk("t1_cmd_ready_after", {63'd0, cmd_ready}, 64'd1);
    chk("t1_busy_after",      {63'd0, busy},      64'd0);

    // 2: specific, ready low 5 cycles; a command offered while busy must be ignored
    drv_ready = 1'b0;
    exp_q.push_back({2'd2, 40'h01DEADBEEF});
    send_cmd(2'd1, 2'd2, 4'd0, 40'h01DEADBEEF);
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("t2_valid",     {63'd0, drv_valid}, 64'd1);
      chk("t2_busy",      {63'd0, busy},      64'd1);
      chk("t2_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      chk("t2_hold",      {22'd0, drv_src, drv_dato}, {22'd0, 2'd2, 40'h01DEADBEEF});
      @(negedge clk);
      if (k == 0) begin
        cmd_op = 2'd1; cmd_src = 2'd3; cmd_data = 40'h5555555555; cmd_valid = 1'b1;
      end
      if (k == 2) cmd_valid = 1'b0;
    end
    drv_ready = 1'b1;
    wait_idle();

    // 3: random burst of 8 from SEED
    exp_q.push_back(FIRST_RND);
    m_lfsr = lfsr_next(m_lfsr);
    push_rnd(7);
    send_cmd(2'd0, 2'd0, 4'd8, '0);
    wait_idle();
`ifdef AGENT_TXN_COUNT_EN
    chk("t3_txn_count", {32'd0, txn_count}, 64'd10);
`else
    chk("t3_txn_count", {32'd0, txn_count}, 64'd0);
`endif

    // 4: length clamping
    push_rnd(DEPTH);
    send_cmd(2'd0, 2'd0, 4'd12, '0);
    wait_idle();
    push_rnd(1);
    send_cmd(2'd0, 2'd0, 4'd0, '0);
    wait_idle();

    // 5: broadcast, then illegal opcode
    exp_q.push_back({2'd1, 40'hFF12345678});
    send_cmd(2'd2, 2'd1, 4'd0, 40'h0012345678);
    wait_idle();
    send_cmd(2'd3, 2'd0, 4'd0, '0);
    #2;
    chk("t5_cmd_err_pulse", {63'd0, cmd_err},   64'd1);
    chk("t5_no_valid",      {63'd0, drv_valid}, 64'd0);
    @(negedge clk); #2;
    chk("t5_cmd_err_drop",  {63'd0, cmd_err},   64'd0);
    chk("t5_idle",          {63'd0, cmd_ready}, 64'd1);

    // 6: reset after 3rd transfer of an 8-txn burst
    do_reset();
    drv_ready = 1'b1;
    base = n_xfer;
    push_rnd(8);
    send_cmd(2'd0, 2'd0, 4'd8, '0);
    n = 0;
    while (n_xfer < base + 3 && n < 100) begin @(negedge clk); #2; n++; end
    chk("t6_three_xfers", {63'd0, (n_xfer >= base + 3)}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_valid_drop", {63'd0, drv_valid}, 64'd0);
    exp_q.delete();
    m_lfsr = SEED;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(FIRST_RND);
    m_lfsr = lfsr_next(m_lfsr);
    send_cmd(2'd0, 2'd0, 4'd1, '0);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
